serial_sub: RTL
===============

# serial_sub

Bit-serial N-bit subtractor computing diff = a − b, LSB first, one bit per clock, with a registered borrow chain. It consumes parallel operands from a start handshake and produces a registered difference plus final borrow with a one-cycle done strobe. It sits directly downstream of the one-bit half-subtractor cell, which it reuses as its per-bit datapath. It is the area-cheap alternative to a ripple subtractor for control paths that tolerate WIDTH-cycle latency.

## Interface
- WIDTH, default 8, operand and result width in bits; legal range WIDTH ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only when the block is not busy.
- a  input  WIDTH  minuend, captured on an accepted start.
- b  input  WIDTH  subtrahend, captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle strobe when the result is valid.
- diff  output  WIDTH  registered result (a − b) mod 2^WIDTH.
- borrow  output  1  registered final borrow-out; 1 iff a < b unsigned.

## Operation
- States are IDLE, SHIFT and DONE. Reset enters IDLE.
- IDLE: start=1 latches a into shift register ra and b into rb, clears the borrow flop bq, clears bit counter cnt, and goes to SHIFT.
- SHIFT: each cycle computes one full-subtract bit from x=ra[0], y=rb[0] and bin=bq:
  - d = x^y^bin
  - bout = (~x&y) | (~(x^y)&bin)
- Also in SHIFT:
  - d shifts into the MSB of accumulator rd, which shifts right.
  - ra and rb shift right; bq ← bout; cnt increments.
- After the WIDTH-th bit, diff ← final rd value and borrow ← final bout (both in the same edge), then go to DONE.
- DONE lasts one cycle with done=1. start=1 in DONE is accepted exactly as in IDLE and goes to SHIFT; otherwise the block goes to IDLE.
- start while in SHIFT is ignored. a and b may change freely after the accepting edge.
- diff and borrow change only on the SHIFT→DONE edge. They hold between operations and stay stable while busy.
- cnt width is $clog2(WIDTH)+1. No overflow is possible.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow=0, state IDLE, internal registers 0.
- If start is accepted at edge k:
  - busy=1 from after edge k through edge k+WIDTH, so busy is high for exactly WIDTH cycles.
  - done=1 and the result are valid in the cycle after edge k+WIDTH.
- Latency from the accepting edge to the done cycle is WIDTH+1 edges. Back-to-back throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.
- rst asserted mid-SHIFT immediately forces all reset values with no partial result. The first edge after rst deasserts behaves as IDLE.
- WIDTH=1: busy for one cycle, done on the next cycle.

## Structure
- Sub-module full_sub (combinational, 1 bit) built from two half-subtractor cells plus an OR for the borrow; instantiated once.
- Shared package serial_sub_pkg:
  - state encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2
  - the default WIDTH constant
- The FSM, counter and shift registers live in serial_sub. The expected implementation size is about 150 lines.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse → busy high exactly 8 cycles, then done for 1 cycle, diff=0x1E, borrow=0.
- a=0x00, b=0x01 → diff=0xFF, borrow=1. Then a=0x80, b=0x80 → diff=0x00, borrow=0, which confirms bq is cleared between operations.
- Start pulse with a=0x10, b=0x01, then start held high with a=0xFF, b=0xFF during SHIFT → ignored; result is diff=0x0F, borrow=0. With start still high in DONE, the second operation (0xFF−0xFF) begins immediately and yields diff=0x00 on the next done.
- rst asserted at the 4th SHIFT cycle of 0x5A−0x3C → busy, done, diff and borrow read 0 immediately. A new start afterward yields the correct result.
- WIDTH=1 instance: a=0, b=1 → done after 2 edges, diff=1, borrow=1. All four input combinations checked against the half-subtractor truth table.
- Randomized 200 operand pairs at WIDTH=8 against the reference model {borrow,diff} = {1'b0,a} − {1'b0,b}, with done spacing exactly 9 cycles under continuous start.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor.
//   S_IDLE/S_SHIFT/S_DONE : FSM state encodings
//   DefaultWidth          : default operand width
package serial_sub_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StShift = S_SHIFT,
    StDone  = S_DONE
  } state_e;

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor from two half-subtractor cells.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit x - y - bin
//   bout : borrow out
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d0;
  logic b0;
  logic b1;

  half_sub u_hs0 (
    .x  (x),
    .y  (y),
    .d  (d0),
    .bo (b0)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_sub u_hs1 (
    .x  (d0),
    .y  (bin),
    .d  (d),
    .bo (b1)
  );

  assign bout = b0 | b1;

endmodule

// File: rtl/serial_sub_half_sub.sv
// One-bit half-subtractor cell.
//   x, y : operand bits
//   d    : x - y difference bit
//   bo   : borrow out (x < y)
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, sampled in IDLE or DONE
//   a, b     : minuend / subtrahend, captured on accepted start
//   busy     : high while bits are processed (WIDTH cycles)
//   done     : one-cycle strobe when diff/borrow are valid
//   diff     : registered (a - b) mod 2^WIDTH
//   borrow   : registered final borrow, 1 iff a < b
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             bq_q, bq_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] rd_shifted;

  full_sub u_full_sub (
    .x    (ra_q[0]),
    .y    (rb_q[0]),
    .bin  (bq_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // New bit enters at the MSB; shift form also works for WIDTH == 1.
  assign rd_shifted = (rd_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    bq_d     = bq_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          bq_d    = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        rd_d  = rd_shifted;
        bq_d  = bit_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          diff_d   = rd_shifted;
          borrow_d = bit_bout;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      bq_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rd_q     <= rd_d;
      bq_q     <= bq_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
